// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control unit: one-hot opcodes, ALU commands and
// the sequencer state type.
package cpu_pkg;

  localparam logic [7:0] OP_STORE   = 8'h01;
  localparam logic [7:0] OP_LOAD    = 8'h02;
  localparam logic [7:0] OP_STOP    = 8'h04;
  localparam logic [7:0] OP_JUMP    = 8'h08;
  localparam logic [7:0] OP_M_STORE = 8'h10;
  localparam logic [7:0] OP_INC     = 8'h20;
  localparam logic [7:0] OP_DEC     = 8'h40;
  localparam logic [7:0] OP_ADD     = 8'h80;

  localparam logic [1:0] ALU_ONE  = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_SWAP = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    FETCH1,
    DECODE,
    LOADWB,
    ALUWB,
    HALT
  } ctrl_state_t;

endpackage

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer: fetches 2-byte instructions, drives the ALU
// command interface and owns PC, ACC, status flags and halt/illegal state.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] mem_addr,
  output logic       mem_re,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       alu_en,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_flag_zero,
  input  logic       alu_flag_carry,
  output logic [7:0] acc,
  output logic [7:0] pc,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted,
  output logic       illegal
);

  ctrl_state_t state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  acc_q, acc_d;
  logic        z_q, z_d;
  logic        c_q, c_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      acc_q     <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      z_q       <= z_d;
      c_q       <= c_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes derive from state_q only, so the async reset clears them at once.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    z_d       = z_q;
    c_d       = c_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = acc_q;
    alu_en    = 1'b0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH0;
      end
      FETCH0: begin
        mem_addr = pc_q;
        mem_re   = 1'b1;
        state_d  = FETCH1;
      end
      FETCH1: begin
        ir_d     = mem_rdata;
        mem_addr = pc_q + 8'd1;
        mem_re   = 1'b1;
        pc_d     = pc_q + 8'd2;
        state_d  = DECODE;
      end
      DECODE: begin
        state_d = FETCH0;
        case (ir_q)
          OP_STORE: acc_d = mem_rdata;
          OP_JUMP:  pc_d  = mem_rdata;
          OP_LOAD: begin
            mem_addr = mem_rdata;
            mem_re   = 1'b1;
            state_d  = LOADWB;
          end
          OP_M_STORE: begin
            mem_addr = mem_rdata;
            mem_we   = 1'b1;
          end
          OP_INC, OP_DEC: begin
            alu_en  = 1'b1;
            alu_op  = ALU_ONE;
            alu_a   = ir_q;
            alu_b   = acc_q;
            state_d = ALUWB;
          end
          OP_ADD: begin
            alu_en  = 1'b1;
            alu_op  = ALU_ADD;
            alu_a   = acc_q;
            alu_b   = mem_rdata;
            state_d = ALUWB;
          end
          OP_STOP: begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
          default: begin
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = HALT;
          end
        endcase
      end
      LOADWB: begin
        acc_d   = mem_rdata;
        state_d = FETCH0;
      end
      ALUWB: begin
        acc_d   = alu_out;
        z_d     = alu_flag_zero;
        c_d     = alu_flag_carry;
        state_d = FETCH0;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign acc     = acc_q;
  assign pc      = pc_q;
  assign flag_z  = z_q;
  assign flag_c  = c_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: memory and ALU models around the DUT, directed
// programs plus random programs checked against an instruction-level interpreter.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] mem_addr, mem_wdata, alu_a, alu_b, acc, pc;
  logic [7:0] mem_rdata = '0;
  logic [7:0] alu_out = '0;
  logic       mem_re, mem_we, alu_en, flag_z, flag_c, halted, illegal;
  logic       alu_flag_zero = 1'b0;
  logic       alu_flag_carry = 1'b0;
  logic [1:0] alu_op;

  cpu_control_unit #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flag_zero(alu_flag_zero), .alu_flag_carry(alu_flag_carry),
    .acc(acc), .pc(pc), .flag_z(flag_z), .flag_c(flag_c),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Program image written by the stimulus; copied into memory while do_load is high.
  logic [7:0] img [256];
  logic [7:0] mem [256];
  logic       do_load = 1'b0;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  // ALU: ONE increments alu_b when alu_a is the INC opcode, otherwise decrements.
  logic [8:0] alu_t;
  always @(posedge clk) begin
    if (alu_en) begin
      case (alu_op)
        2'b00:   alu_t = (alu_a == 8'h20) ? {1'b0, alu_b} + 9'd1 : {1'b0, alu_b} - 9'd1;
        2'b01:   alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        2'b10:   alu_t = {1'b0, alu_a} - {1'b0, alu_b};
        default: alu_t = {1'b0, alu_a[3:0], alu_a[7:4]};
      endcase
      alu_out        <= alu_t[7:0];
      alu_flag_zero  <= (alu_t[7:0] == 8'h00);
      alu_flag_carry <= alu_t[8];
    end
  end

  // Activity monitor
  logic cnt_clr = 1'b1;
  int   cyc, re_cnt, we_cnt, alu_cnt, re20_cyc, aa_cyc;
  always @(posedge clk) begin
    if (cnt_clr) begin
      cyc <= 0; re_cnt <= 0; we_cnt <= 0; alu_cnt <= 0; re20_cyc <= -1; aa_cyc <= -1;
    end else begin
      cyc <= cyc + 1;
      if (mem_re) re_cnt <= re_cnt + 1;
      if (mem_we) we_cnt <= we_cnt + 1;
      if (alu_en) alu_cnt <= alu_cnt + 1;
      if (mem_re && mem_addr == 8'h20 && re20_cyc < 0) re20_cyc <= cyc;
      if (acc == 8'hAA && aa_cyc < 0) aa_cyc <= cyc;
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Instruction-level reference interpreter
  logic [7:0] ref_mem [256];
  logic [7:0] r_acc, r_pc;
  logic       r_z, r_c, r_halt, r_ill;
  int         r_cycles;

  task automatic run_model(input int max_instr);
    logic [7:0] op, opd;
    logic [8:0] t;
    for (int i = 0; i < 256; i++) ref_mem[i] = img[i];
    r_acc = 0; r_pc = 0; r_z = 0; r_c = 0; r_halt = 0; r_ill = 0; r_cycles = 0;
    for (int n = 0; n < max_instr && !r_halt; n++) begin
      op  = ref_mem[r_pc];
      opd = ref_mem[8'(r_pc + 8'd1)];
      r_pc = r_pc + 8'd2;
      r_cycles += 3;
      case (op)
        8'h01: r_acc = opd;
        8'h08: r_pc = opd;
        8'h02: begin r_acc = ref_mem[opd]; r_cycles += 1; end
        8'h10: ref_mem[opd] = r_acc;
        8'h20, 8'h40, 8'h80: begin
          if (op == 8'h20)      t = r_acc + 9'd1;
          else if (op == 8'h40) t = {1'b0, r_acc} - 9'd1;
          else                  t = r_acc + opd;
          r_acc = t[7:0]; r_c = t[8]; r_z = (t[7:0] == 0);
          r_cycles += 1;
        end
        8'h04: r_halt = 1;
        default: begin r_halt = 1; r_ill = 1; end
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; do_load = 1'b1; cnt_clr = 1'b1;
    tick(2);
    do_load = 1'b0;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cnt_clr = 1'b0;
    tick(1);
    start = 1'b0;
  endtask

  // Load img, run DUT for the cycle count the model predicts, compare architectural state.
  task automatic run_prog(input string tag, input int max_instr);
    int diff;
    run_model(max_instr);
    do_reset();
    pulse_start();
    if (r_halt) begin
      tick(r_cycles - 1);
      chk({tag, ".halt_early"}, halted, 0);
      tick(1);
    end else begin
      tick(r_cycles);
    end
    chk({tag, ".acc"}, acc, r_acc);
    chk({tag, ".pc"}, pc, r_pc);
    chk({tag, ".z"}, flag_z, r_z);
    chk({tag, ".c"}, flag_c, r_c);
    chk({tag, ".halted"}, halted, r_halt);
    chk({tag, ".illegal"}, illegal, r_ill);
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk({tag, ".mem_diff"}, diff, 0);
  endtask

  task automatic set_img(input logic [7:0] bytes[$]);
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    for (int i = 0; i < bytes.size(); i++) img[i] = bytes[i];
  endtask

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    do_reset();
    chk("reset.acc", acc, 0);
    chk("reset.pc", pc, 0);
    chk("reset.flags", {flag_z, flag_c}, 0);
    chk("reset.halt_ill", {halted, illegal}, 0);
    chk("reset.strobes", {mem_re, mem_we, alu_en}, 0);
    tick(3);
    chk("idle.no_fetch", re_cnt, 0);

    // T1
    set_img('{8'h01, 8'h05, 8'h20, 8'h00, 8'h10, 8'h40, 8'h04, 8'h00});
    run_prog("t1", 50);
    chk("t1.mem40", mem[8'h40], 8'h06);
    chk("t1.acc_spec", acc, 8'h06);
    chk("t1.pc_spec", pc, 8'h08);
    chk("t1.flags_spec", {flag_z, halted, illegal}, 3'b010);

    // T2
    set_img('{8'h01, 8'h00, 8'h40, 8'h00, 8'h04, 8'h00});
    run_prog("t2", 50);
    chk("t2.spec", {acc, flag_c, flag_z}, {8'hFF, 1'b1, 1'b0});

    // T3
    set_img('{8'h01, 8'hF0, 8'h80, 8'h20, 8'h04, 8'h00});
    run_prog("t3a", 50);
    chk("t3a.spec", {acc, flag_c}, {8'h10, 1'b1});
    set_img('{8'h01, 8'hFF, 8'h20, 8'h00});
    run_prog("t3b", 50);
    chk("t3b.spec", {acc, flag_z}, {8'h00, 1'b1});

    // T4
    set_img('{8'h08, 8'h10});
    img[8'h10] = 8'h02; img[8'h11] = 8'h20; img[8'h12] = 8'h04; img[8'h20] = 8'hAA;
    run_prog("t4", 50);
    chk("t4.spec", {acc, pc, halted}, {8'hAA, 8'h14, 1'b1});
    chk("t4.loadwb_latency", aa_cyc - re20_cyc, 2);

    // T5
    set_img('{8'h03, 8'h00});
    run_prog("t5", 50);
    chk("t5.spec", {halted, illegal}, 2'b11);
    chk("t5.no_we_alu", we_cnt + alu_cnt, 0);
    pulse_start();
    tick(4);
    chk("t5.start_ignored_pc", pc, 8'h02);
    chk("t5.start_ignored_re", re_cnt, 2);

    // T6: reset during ALUWB of INC
    set_img('{8'h01, 8'h05, 8'h20, 8'h00, 8'h10, 8'h40, 8'h04, 8'h00});
    do_reset();
    pulse_start();
    tick(5);
    chk("t6.alu_en_decode", alu_en, 1);
    tick(1);
    rst = 1'b1;
    #1;
    chk("t6.async_acc", acc, 0);
    chk("t6.async_pc", pc, 0);
    chk("t6.async_strobes", {mem_re, mem_we, alu_en}, 0);
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("t6.idle_after", {mem_re, acc}, 0);
    run_prog("t6_rerun", 50);
    chk("t6.mem40", mem[8'h40], 8'h06);

    // PC wrap
    set_img('{8'h08, 8'hFF});
    img[8'hFF] = 8'h01;
    run_prog("wrap", 50);
    chk("wrap.spec", {acc, illegal}, {8'h08, 1'b1});

    // Random programs
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(255, 0));
      for (int i = 0; i < 64; i += 2) begin
        case ($urandom_range(15, 0))
          0, 1:    img[i] = 8'h01;
          2, 3:    img[i] = 8'h02;
          4:       begin img[i] = 8'h08; img[i+1] = 8'($urandom_range(31, 0) * 2); continue; end
          5, 6:    img[i] = 8'h10;
          7, 8:    img[i] = 8'h20;
          9, 10:   img[i] = 8'h40;
          11, 12, 13: img[i] = 8'h80;
          14:      img[i] = 8'h04;
          default: img[i] = 8'($urandom_range(255, 0));
        endcase
        img[i+1] = 8'($urandom_range(255, 0));
      end
      run_prog($sformatf("rand%0d", p), 40);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
